// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the memory stage and any future
//            load/store unit: memory-op encoding, funct3 size/sign codes,
//            memory-stage FSM states and a misalignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Memory operation carried down the pipeline (encoding 3 behaves as NONE)
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  // funct3 access size / signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  // funct3[1] set selects a word access, else funct3[0] selects a halfword.
  // Bytes are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    if (funct3[1])      mis = |addr_lo;
    else if (funct3[0]) mis = addr_lo[0];
    else                mis = 1'b0;
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_load_align.sv
`default_nettype none
// ============================================================================
// Module   : riscv_load_align
// Purpose  : Combinational load-data alignment. Shifts the addressed lane of
//            the response word down to bit 0 and sign/zero-extends it.
// Ports    : rdata_i  [31:0] raw response word
//            lane_i   [1:0]  byte offset of the access within the word
//            funct3_i [2:0]  access size / signedness
//            result_o [31:0] aligned, extended load value
// Revision : 1.0 - initial release
// ============================================================================
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    result_o = shifted;  // word and unlisted encodings
    case (funct3_i)
      F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result_o = {24'd0, shifted[7:0]};
      F3_HU:   result_o = {16'd0, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_stage
// Purpose  : Pipeline memory stage. Non-memory ops pass the ALU result through
//            in one cycle; loads/stores issue a valid/ready data-memory request,
//            loads wait for the response which is then aligned and extended.
//            mem_stall_o is high whenever the stage is not idle.
// Ports    : clk, rst_n (async, active-low)
//            ex4_*_i        upstream slot (result/address, rd, op, funct3, data)
//            mem_stall_o    upstream freeze
//            dmem_req_*     request channel (valid/ready, addr, we, be, wdata)
//            dmem_rsp_*_i   load response (valid, rdata)
//            mem_*_o        writeback result, rd, valid pulse, misaligned, err
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 255
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ex4_alu_result_i,
  input  logic [4:0]      ex4_rd_addr_i,
  input  logic            ex4_valid_i,
  input  logic [1:0]      ex4_mem_op_i,
  input  logic [2:0]      ex4_funct3_i,
  input  logic [XLEN-1:0] ex4_store_data_i,
  output logic            mem_stall_o,
  output logic            dmem_req_valid_o,
  input  logic            dmem_req_ready_i,
  output logic [XLEN-1:0] dmem_req_addr_o,
  output logic            dmem_req_we_o,
  output logic [3:0]      dmem_req_be_o,
  output logic [XLEN-1:0] dmem_req_wdata_o,
  input  logic            dmem_rsp_valid_i,
  input  logic [XLEN-1:0] dmem_rsp_rdata_i,
  output logic [XLEN-1:0] mem_result_o,
  output logic [4:0]      mem_rd_addr_o,
  output logic            mem_valid_o,
  output logic            mem_misaligned_o,
  output logic            mem_err_o
);

  localparam logic       TMO_EN   = (RSP_TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

  mem_state_e state_q, state_d;
  logic [7:0] tmo_q, tmo_d;

  // Captured request (data fields unreset)
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q;
  logic [1:0]      lane_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            we_q;

  // Output registers
  logic            valid_q, mis_q, err_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  // Next-cycle output controls
  logic            out_load, out_mis, out_err, capture;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;

  logic            is_load, is_store, misaligned;
  logic [XLEN-1:0] aligned_data;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;

  assign is_load    = (ex4_mem_op_i == MEM_LOAD);
  assign is_store   = (ex4_mem_op_i == MEM_STORE);
  assign misaligned = is_misaligned(ex4_funct3_i, ex4_alu_result_i[1:0]);

  riscv_load_align u_align (
    .rdata_i  (dmem_rsp_rdata_i),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .result_o (aligned_data)
  );

  // Store lane enables and replicated data; loads carry no byte enables
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = ex4_store_data_i;
    if (ex4_funct3_i[1]) begin
      be_d    = 4'b1111;
    end else if (ex4_funct3_i[0]) begin
      be_d    = 4'b0011 << ex4_alu_result_i[1:0];
      wdata_d = {2{ex4_store_data_i[15:0]}};
    end else begin
      be_d    = 4'b0001 << ex4_alu_result_i[1:0];
      wdata_d = {4{ex4_store_data_i[7:0]}};
    end
    if (!is_store) be_d = 4'b0000;
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    capture    = 1'b0;
    out_load   = 1'b0;
    out_mis    = 1'b0;
    out_err    = 1'b0;
    out_result = ex4_alu_result_i;
    out_rd     = 5'd0;
    case (state_q)
      IDLE: begin
        if (ex4_valid_i) begin
          if ((is_load || is_store) && misaligned) begin
            out_load = 1'b1;
            out_mis  = 1'b1;
          end else if (is_load || is_store) begin
            capture  = 1'b1;
            state_d  = REQ;
          end else begin
            out_load = 1'b1;
            out_rd   = ex4_rd_addr_i;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready_i) begin
          if (we_q) begin
            state_d    = IDLE;
            out_load   = 1'b1;
            out_result = addr_q;
          end else begin
            state_d = WAIT;
            tmo_d   = 8'd0;
          end
        end
      end
      WAIT: begin
        if (dmem_rsp_valid_i) begin
          state_d    = IDLE;
          out_load   = 1'b1;
          out_result = aligned_data;
          out_rd     = rd_q;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          state_d    = IDLE;
          out_load   = 1'b1;
          out_err    = 1'b1;
          out_result = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q   <= 8'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      valid_q <= out_load;
      mis_q   <= out_mis;
      err_q   <= out_err;
    end
  end

  // Data path registers carry no reset; they are only observed when qualified
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= {ex4_alu_result_i[XLEN-1:2], 2'b00};
      lane_q  <= ex4_alu_result_i[1:0];
      f3_q    <= ex4_funct3_i;
      rd_q    <= ex4_rd_addr_i;
      we_q    <= is_store;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
    if (out_load) begin
      result_q <= out_result;
      rd_out_q <= out_rd;
    end
  end

  assign mem_stall_o      = (state_q != IDLE);
  assign dmem_req_valid_o = (state_q == REQ);
  assign dmem_req_addr_o  = addr_q;
  assign dmem_req_we_o    = we_q;
  assign dmem_req_be_o    = be_q;
  assign dmem_req_wdata_o = wdata_q;
  assign mem_result_o     = result_q;
  assign mem_rd_addr_o    = rd_out_q;
  assign mem_valid_o      = valid_q;
  assign mem_misaligned_o = mis_q;
  assign mem_err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_stage
// Purpose  : Self-checking bench for riscv_mem_stage. Expected writeback
//            results are queued when an instruction is driven and compared
//            by a monitor whenever mem_valid_o pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_stage;

  localparam int RSP_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ex4_alu_result;
  logic [4:0]  ex4_rd_addr;
  logic        ex4_valid;
  logic [1:0]  ex4_mem_op;
  logic [2:0]  ex4_funct3;
  logic [31:0] ex4_store_data;
  logic        mem_stall;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_result;
  logic [4:0]  mem_rd_addr;
  logic        mem_valid;
  logic        mem_mis;
  logic        mem_err;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        mis;
    logic        err;
    logic        chk_res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  riscv_mem_stage #(.XLEN(32), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex4_alu_result_i (ex4_alu_result),
    .ex4_rd_addr_i    (ex4_rd_addr),
    .ex4_valid_i      (ex4_valid),
    .ex4_mem_op_i     (ex4_mem_op),
    .ex4_funct3_i     (ex4_funct3),
    .ex4_store_data_i (ex4_store_data),
    .mem_stall_o      (mem_stall),
    .dmem_req_valid_o (req_valid),
    .dmem_req_ready_i (req_ready),
    .dmem_req_addr_o  (req_addr),
    .dmem_req_we_o    (req_we),
    .dmem_req_be_o    (req_be),
    .dmem_req_wdata_o (req_wdata),
    .dmem_rsp_valid_i (rsp_valid),
    .dmem_rsp_rdata_i (rsp_rdata),
    .mem_result_o     (mem_result),
    .mem_rd_addr_o    (mem_rd_addr),
    .mem_valid_o      (mem_valid),
    .mem_misaligned_o (mem_mis),
    .mem_err_o        (mem_err)
  );

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mem_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_mem_valid: got result=%h rd=%0d mis=%b err=%b, expected no output",
                 mem_result, mem_rd_addr, mem_mis, mem_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((mem_rd_addr !== e.rd) || (mem_mis !== e.mis) || (mem_err !== e.err) ||
            (e.chk_res && (mem_result !== e.res))) begin
          n_fail++;
          $display("FAIL writeback: got result=%h rd=%0d mis=%b err=%b, expected result=%h(chk=%b) rd=%0d mis=%b err=%b",
                   mem_result, mem_rd_addr, mem_mis, mem_err, e.res, e.chk_res, e.rd, e.mis, e.err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [4:0] rd, input logic [31:0] data);
    ex4_valid      = 1'b1;
    ex4_mem_op     = op;
    ex4_funct3     = f3;
    ex4_alu_result = addr;
    ex4_rd_addr    = rd;
    ex4_store_data = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({mem_valid, mem_stall, req_valid, mem_mis, mem_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid/stall/req/mis/err=%b, expected 00000",
               {mem_valid, mem_stall, req_valid, mem_mis, mem_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_none_stream();
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 3'b000, 32'(i + 1), 5'(i + 1), 32'd0);
      sb.push_back('{res: 32'(i + 1), rd: 5'(i + 1), mis: 1'b0, err: 1'b0, chk_res: 1'b1});
      step();
      n_checks++;
      if (mem_valid !== 1'b1 || mem_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL none_stream[%0d]: got valid=%b stall=%b, expected valid=1 stall=0",
                 i, mem_valid, mem_stall);
      end
    end
    ex4_valid = 1'b0;
    step();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL none_stream_end: got valid=%b, expected 0", mem_valid);
    end
  endtask

  // Load with ready=1 and response one cycle after acceptance
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp_res);
    req_ready = 1'b1;
    drive(2'd1, f3, addr, rd, 32'd0);
    sb.push_back('{res: exp_res, rd: rd, mis: 1'b0, err: 1'b0, chk_res: 1'b1});
    step();
    ex4_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== {addr[31:2], 2'b00} || req_we !== 1'b0 ||
        req_be !== 4'b0000 || mem_stall !== 1'b1 || mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_req@%h: got valid=%b addr=%h we=%b be=%b stall=%b mv=%b, expected 1 %h 0 0000 1 0",
               addr, req_valid, req_addr, req_we, req_be, mem_stall, mem_valid, {addr[31:2], 2'b00});
    end
    step();
    n_checks++;
    if (req_valid !== 1'b0 || mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_wait@%h: got req_valid=%b stall=%b, expected 0 1", addr, req_valid, mem_stall);
    end
    rsp_valid = 1'b1;
    rsp_rdata = rdata;
    step();
    rsp_valid = 1'b0;
    n_checks++;
    if (mem_valid !== 1'b1 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_latency@%h: got valid=%b stall=%b, expected 1 0", addr, mem_valid, mem_stall);
    end
  endtask

  task automatic test_lb();
    run_load(3'b000, 32'h0000_0103, 5'd5, 32'h80FF_FF00, 32'hFFFF_FF80);
  endtask

  task automatic test_load_variants();
    run_load(3'b001, 32'h0000_0006, 5'd6,  32'h8001_0000, 32'hFFFF_8001);
    run_load(3'b101, 32'h0000_0006, 5'd7,  32'h8001_0000, 32'h0000_8001);
    run_load(3'b100, 32'h0000_0001, 5'd8,  32'h0000_8000, 32'h0000_0080);
    run_load(3'b010, 32'h0000_0008, 5'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load(3'b000, 32'h0000_0002, 5'd11, 32'h007F_0000, 32'h0000_007F);
  endtask

  task automatic check_store_req(input string nm, input logic [31:0] ea, input logic [3:0] be,
                                 input logic [31:0] wd);
    n_checks++;
    if (req_valid !== 1'b1 || req_we !== 1'b1 || req_addr !== ea || req_be !== be ||
        req_wdata !== wd || mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got valid=%b we=%b addr=%h be=%b wdata=%h stall=%b, expected 1 1 %h %b %h 1",
               nm, req_valid, req_we, req_addr, req_be, req_wdata, mem_stall, ea, be, wd);
    end
  endtask

  task automatic test_store_held();
    req_ready = 1'b0;
    drive(2'd2, 3'b001, 32'h0000_0202, 5'd7, 32'h1234_ABCD);
    sb.push_back('{res: 32'd0, rd: 5'd0, mis: 1'b0, err: 1'b0, chk_res: 1'b0});
    step();
    ex4_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_store_req("sh_held", 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
      step();
    end
    check_store_req("sh_accept", 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    req_ready = 1'b1;
    step();
    n_checks++;
    if (mem_valid !== 1'b1 || req_valid !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_done: got valid=%b req=%b stall=%b, expected 1 0 0", mem_valid, req_valid, mem_stall);
    end
  endtask

  task automatic test_store_variants();
    req_ready = 1'b1;
    drive(2'd2, 3'b000, 32'h0000_0301, 5'd12, 32'hFFFF_FF55);
    sb.push_back('{res: 32'd0, rd: 5'd0, mis: 1'b0, err: 1'b0, chk_res: 1'b0});
    step();
    ex4_valid = 1'b0;
    check_store_req("sb", 32'h0000_0300, 4'b0010, 32'h5555_5555);
    step();
    drive(2'd2, 3'b010, 32'h0000_0400, 5'd13, 32'hCAFE_F00D);
    sb.push_back('{res: 32'd0, rd: 5'd0, mis: 1'b0, err: 1'b0, chk_res: 1'b0});
    step();
    ex4_valid = 1'b0;
    check_store_req("sw", 32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
    step();
  endtask

  task automatic test_misaligned();
    drive(2'd1, 3'b010, 32'h0000_0101, 5'd3, 32'd0);
    sb.push_back('{res: 32'd0, rd: 5'd0, mis: 1'b1, err: 1'b0, chk_res: 1'b0});
    step();
    drive(2'd2, 3'b001, 32'h0000_0203, 5'd4, 32'h1111_2222);
    sb.push_back('{res: 32'd0, rd: 5'd0, mis: 1'b1, err: 1'b0, chk_res: 1'b0});
    n_checks++;
    if (req_valid !== 1'b0 || mem_valid !== 1'b1 || mem_mis !== 1'b1 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_misaligned: got req=%b valid=%b mis=%b stall=%b, expected 0 1 1 0",
               req_valid, mem_valid, mem_mis, mem_stall);
    end
    step();
    ex4_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b0 || mem_valid !== 1'b1 || mem_mis !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_misaligned: got req=%b valid=%b mis=%b, expected 0 1 1", req_valid, mem_valid, mem_mis);
    end
    step();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    req_ready = 1'b1;
    drive(2'd1, 3'b101, 32'h0000_0002, 5'd9, 32'd0);
    sb.push_back('{res: 32'd0, rd: 5'd0, mis: 1'b0, err: 1'b1, chk_res: 1'b1});
    step();
    ex4_valid = 1'b0;
    step();
    while (cnt < 400) begin
      step();
      cnt++;
      if (mem_valid === 1'b1) break;
    end
    n_checks++;
    if (mem_valid !== 1'b1 || mem_err !== 1'b1 || cnt < RSP_TIMEOUT || cnt > RSP_TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout: got valid=%b err=%b after %0d cycles, expected 1 1 after %0d cycles",
               mem_valid, mem_err, cnt, RSP_TIMEOUT);
    end
    rsp_valid = 1'b1;
    rsp_rdata = 32'h1234_5678;
    step();
    rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (mem_stall !== 1'b0 || mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rsp: got stall=%b valid=%b, expected 0 0", mem_stall, mem_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    req_ready = 1'b1;
    drive(2'd1, 3'b010, 32'h0000_0010, 5'd4, 32'd0);
    step();
    ex4_valid = 1'b0;
    step();
    n_checks++;
    if (mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_entry: got stall=%b, expected 1", mem_stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_stall !== 1'b0 || req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got stall=%b req=%b, expected 0 0", mem_stall, req_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rsp_valid = 1'b1;
    rsp_rdata = 32'hAAAA_5555;
    step();
    rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (mem_valid !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_after_reset: got valid=%b stall=%b, expected 0 0", mem_valid, mem_stall);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ex4_valid      = 1'b0;
    ex4_mem_op     = 2'd0;
    ex4_funct3     = 3'd0;
    ex4_alu_result = 32'd0;
    ex4_rd_addr    = 5'd0;
    ex4_store_data = 32'd0;
    req_ready      = 1'b1;
    rsp_valid      = 1'b0;
    rsp_rdata      = 32'd0;

    test_reset();
    test_none_stream();
    test_lb();
    test_load_variants();
    test_store_held();
    test_store_variants();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding results, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
